// File: rtl/alu_issue_pkg.sv
// Shared constants and the decode record for the alu_issue stage.
package alu_issue_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ALU_OP_BITS = 4;
  localparam int REG_BITS    = 5;
  localparam int CNT_BITS    = 16;
  localparam int OPC_BITS    = 6;
  localparam int IMM_BITS    = 16;

  localparam logic [OPC_BITS-1:0] OPC_ADD  = 6'h00;
  localparam logic [OPC_BITS-1:0] OPC_SUB  = 6'h01;
  localparam logic [OPC_BITS-1:0] OPC_NOT  = 6'h02;
  localparam logic [OPC_BITS-1:0] OPC_AND  = 6'h03;
  localparam logic [OPC_BITS-1:0] OPC_OR   = 6'h04;
  localparam logic [OPC_BITS-1:0] OPC_NAND = 6'h05;
  localparam logic [OPC_BITS-1:0] OPC_NOR  = 6'h06;
  localparam logic [OPC_BITS-1:0] OPC_MOVA = 6'h07;
  localparam logic [OPC_BITS-1:0] OPC_LI   = 6'h08;
  localparam logic [OPC_BITS-1:0] OPC_ADDI = 6'h10;
  localparam logic [OPC_BITS-1:0] OPC_LW   = 6'h11;
  localparam logic [OPC_BITS-1:0] OPC_SW   = 6'h12;
  localparam logic [OPC_BITS-1:0] OPC_BEQ  = 6'h13;

  localparam logic [ALU_OP_BITS-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_BITS-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_BITS-1:0] ALU_NOT  = 4'd2;
  localparam logic [ALU_OP_BITS-1:0] ALU_AND  = 4'd3;
  localparam logic [ALU_OP_BITS-1:0] ALU_OR   = 4'd4;
  localparam logic [ALU_OP_BITS-1:0] ALU_NAND = 4'd5;
  localparam logic [ALU_OP_BITS-1:0] ALU_NOR  = 4'd6;
  localparam logic [ALU_OP_BITS-1:0] ALU_MOVA = 4'd7;
  localparam logic [ALU_OP_BITS-1:0] ALU_LI   = 4'd8;

  // wr_rd means "writes rd when rd is not r0"; the r0 check lives in the top.
  typedef struct packed {
    logic [ALU_OP_BITS-1:0] alu_op;
    logic                   imm_sel;
    logic                   uses_rs;
    logic                   uses_rt;
    logic                   wr_rd;
    logic                   is_load;
    logic                   is_store;
    logic                   is_branch;
    logic                   illegal;
  } dec_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Opcode decoder: pure combinational opcode -> ALU op, operand selects and flags.
// Sources that an instruction does not read are marked unused so they never stall.
module alu_issue_decode import alu_issue_pkg::*; (
  input  logic [OPC_BITS-1:0] opcode,
  output dec_t                dec
);

  // Table lookup with everything defaulted to zero so unlisted opcodes read as illegal.
  always_comb begin
    dec = '0;
    unique case (opcode)
      OPC_ADD:  begin dec.alu_op = ALU_ADD;  dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; dec.wr_rd = 1'b1; end
      OPC_SUB:  begin dec.alu_op = ALU_SUB;  dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; dec.wr_rd = 1'b1; end
      OPC_NOT:  begin dec.alu_op = ALU_NOT;  dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; dec.wr_rd = 1'b1; end
      OPC_AND:  begin dec.alu_op = ALU_AND;  dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; dec.wr_rd = 1'b1; end
      OPC_OR:   begin dec.alu_op = ALU_OR;   dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; dec.wr_rd = 1'b1; end
      OPC_NAND: begin dec.alu_op = ALU_NAND; dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; dec.wr_rd = 1'b1; end
      OPC_NOR:  begin dec.alu_op = ALU_NOR;  dec.uses_rs = 1'b1; dec.uses_rt = 1'b1; dec.wr_rd = 1'b1; end
      OPC_MOVA: begin dec.alu_op = ALU_MOVA; dec.uses_rs = 1'b1; dec.wr_rd = 1'b1; end
      OPC_LI:   begin dec.alu_op = ALU_LI;   dec.imm_sel = 1'b1; dec.wr_rd = 1'b1; end
      OPC_ADDI: begin dec.alu_op = ALU_ADD;  dec.uses_rs = 1'b1; dec.imm_sel = 1'b1; dec.wr_rd = 1'b1; end
      OPC_LW: begin
        dec.alu_op  = ALU_ADD;
        dec.uses_rs = 1'b1;
        dec.imm_sel = 1'b1;
        dec.wr_rd   = 1'b1;
        dec.is_load = 1'b1;
      end
      // Store reads rt for its data even though data2 carries the offset.
      OPC_SW: begin
        dec.alu_op   = ALU_ADD;
        dec.uses_rs  = 1'b1;
        dec.uses_rt  = 1'b1;
        dec.imm_sel  = 1'b1;
        dec.is_store = 1'b1;
      end
      OPC_BEQ: begin
        dec.alu_op    = ALU_SUB;
        dec.uses_rs   = 1'b1;
        dec.uses_rt   = 1'b1;
        dec.is_branch = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage feeding the ALU: operand resolution, load-use interlock,
// registered valid/ready output stage and a saturating stall counter.
// Build option: define ALU_ISSUE_FWD_EN to forward EX/WB results; without it
// every pending EX or WB write to a used source interlocks instead.
module alu_issue import alu_issue_pkg::*; (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPC_BITS-1:0]    in_opcode,
  input  logic [REG_BITS-1:0]    in_rd,
  input  logic [REG_BITS-1:0]    in_rs,
  input  logic [REG_BITS-1:0]    in_rt,
  input  logic [IMM_BITS-1:0]    in_imm,
  output logic [REG_BITS-1:0]    rf_rs_addr,
  output logic [REG_BITS-1:0]    rf_rt_addr,
  input  logic [DATA_WIDTH-1:0]  rf_rs_data,
  input  logic [DATA_WIDTH-1:0]  rf_rt_data,
  input  logic                   ex_wr_en,
  input  logic                   ex_is_load,
  input  logic [REG_BITS-1:0]    ex_wr_addr,
  input  logic [DATA_WIDTH-1:0]  ex_wr_data,
  input  logic                   wb_wr_en,
  input  logic [REG_BITS-1:0]    wb_wr_addr,
  input  logic [DATA_WIDTH-1:0]  wb_wr_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ALU_OP_BITS-1:0] alu_op,
  output logic [DATA_WIDTH-1:0]  data1,
  output logic [DATA_WIDTH-1:0]  data2,
  output logic [REG_BITS-1:0]    out_rd,
  output logic                   out_wr_en,
  output logic                   out_is_load,
  output logic                   out_is_store,
  output logic                   out_is_branch,
  output logic [DATA_WIDTH-1:0]  out_store_data,
  output logic                   illegal_op,
  output logic [CNT_BITS-1:0]    stall_cnt
);

  dec_t                  dec;
  logic                  rs_hz, rt_hz, hazard;
  logic                  adv, fire, accept;
  logic [DATA_WIDTH-1:0] rs_val, rt_val, imm_ext;

  alu_issue_decode u_decode (
    .opcode (in_opcode),
    .dec    (dec)
  );

  assign rf_rs_addr = in_rs;
  assign rf_rt_addr = in_rt;
  assign imm_ext    = {{(DATA_WIDTH-IMM_BITS){in_imm[IMM_BITS-1]}}, in_imm};

`ifdef ALU_ISSUE_FWD_EN
  // Only a load still in EX cannot be forwarded; EX results take priority over WB.
  always_comb begin
    rs_hz = dec.uses_rs && (in_rs != '0) && ex_wr_en && ex_is_load && (ex_wr_addr == in_rs);
    rt_hz = dec.uses_rt && (in_rt != '0) && ex_wr_en && ex_is_load && (ex_wr_addr == in_rt);
    rs_val = rf_rs_data;
    if (in_rs == '0)                                          rs_val = '0;
    else if (ex_wr_en && !ex_is_load && (ex_wr_addr == in_rs)) rs_val = ex_wr_data;
    else if (wb_wr_en && (wb_wr_addr == in_rs))               rs_val = wb_wr_data;
    rt_val = rf_rt_data;
    if (in_rt == '0)                                          rt_val = '0;
    else if (ex_wr_en && !ex_is_load && (ex_wr_addr == in_rt)) rt_val = ex_wr_data;
    else if (wb_wr_en && (wb_wr_addr == in_rt))               rt_val = wb_wr_data;
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_is_load, ex_wr_data, wb_wr_data};

  // No bypass: any in-flight write to a used source interlocks; operands come from the regfile.
  always_comb begin
    rs_hz  = dec.uses_rs && (in_rs != '0) &&
             ((ex_wr_en && (ex_wr_addr == in_rs)) || (wb_wr_en && (wb_wr_addr == in_rs)));
    rt_hz  = dec.uses_rt && (in_rt != '0) &&
             ((ex_wr_en && (ex_wr_addr == in_rt)) || (wb_wr_en && (wb_wr_addr == in_rt)));
    rs_val = (in_rs == '0) ? '0 : rf_rs_data;
    rt_val = (in_rt == '0) ? '0 : rf_rt_data;
  end
`endif

  assign hazard   = in_valid && (rs_hz || rt_hz);
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !hazard;
  assign fire     = in_valid && in_ready;
  assign accept   = fire && !dec.illegal;

  // Output pipeline register: load on accept, bubble on idle/stall, hold while EX back-pressures.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      alu_op         <= '0;
      data1          <= '0;
      data2          <= '0;
      out_rd         <= '0;
      out_wr_en      <= 1'b0;
      out_is_load    <= 1'b0;
      out_is_store   <= 1'b0;
      out_is_branch  <= 1'b0;
      out_store_data <= '0;
      illegal_op     <= 1'b0;
      stall_cnt      <= '0;
    end else begin
      illegal_op <= fire && dec.illegal;
      if (adv) begin
        out_valid <= accept;
        if (accept) begin
          alu_op         <= dec.alu_op;
          data1          <= dec.uses_rs ? rs_val : '0;
          data2          <= dec.imm_sel ? imm_ext : (dec.uses_rt ? rt_val : '0);
          out_rd         <= in_rd;
          out_wr_en      <= dec.wr_rd && (in_rd != '0);
          out_is_load    <= dec.is_load;
          out_is_store   <= dec.is_store;
          out_is_branch  <= dec.is_branch;
          out_store_data <= dec.is_store ? rt_val : '0;
        end
        if (hazard && (stall_cnt != {CNT_BITS{1'b1}}))
          stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios followed by random traffic, all
// checked against a cycle model of the issue rules kept in this file.
module tb_alu_issue;

  logic        clk, reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rd, in_rs, in_rt, rf_rs_addr, rf_rt_addr;
  logic [15:0] in_imm;
  logic [31:0] rf_rs_data, rf_rt_data;
  logic        ex_wr_en, ex_is_load, wb_wr_en;
  logic [4:0]  ex_wr_addr, wb_wr_addr, out_rd;
  logic [31:0] ex_wr_data, wb_wr_data, data1, data2, out_store_data;
  logic [3:0]  alu_op;
  logic        out_wr_en, out_is_load, out_is_store, out_is_branch, illegal_op;
  logic [15:0] stall_cnt;

  logic [31:0] regs [32];
  logic [5:0]  op_tab [13];
  int checks = 0;
  int failures = 0;

  // model state: what the stage should be presenting
  bit          m_valid, m_ill, m_c1, m_c2;
  int          m_stall;
  logic [3:0]  m_aop, m_flags;
  logic [31:0] m_d1, m_d2, m_sd;
  logic [4:0]  m_rd;

  alu_issue dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .data1(data1), .data2(data2),
    .out_rd(out_rd), .out_wr_en(out_wr_en), .out_is_load(out_is_load), .out_is_store(out_is_store),
    .out_is_branch(out_is_branch), .out_store_data(out_store_data), .illegal_op(illegal_op),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rf_rs_data = regs[rf_rs_addr];
    rf_rt_data = regs[rf_rt_addr];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction table: what each opcode does in the architectural sense.
  function automatic void mdec(input logic [5:0] op, output bit legal, output logic [3:0] aop,
                               output bit uimm, output bit urs, output bit urt, output bit wrk,
                               output bit ld, output bit st, output bit br);
    legal = 1; aop = 0; uimm = 0; urs = 0; urt = 0; wrk = 0; ld = 0; st = 0; br = 0;
    case (op)
      6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06: begin aop = op[3:0]; urs = 1; urt = 1; wrk = 1; end
      6'h07: begin aop = 7; urs = 1; wrk = 1; end
      6'h08: begin aop = 8; uimm = 1; wrk = 1; end
      6'h10: begin aop = 0; urs = 1; uimm = 1; wrk = 1; end
      6'h11: begin aop = 0; urs = 1; uimm = 1; wrk = 1; ld = 1; end
      6'h12: begin aop = 0; urs = 1; urt = 1; uimm = 1; st = 1; end
      6'h13: begin aop = 1; urs = 1; urt = 1; br = 1; end
      default: legal = 0;
    endcase
  endfunction

  // Architectural value of register a as seen by the instruction being issued.
  function automatic logic [31:0] mval(input logic [4:0] a);
    if (a == 0) return 32'd0;
`ifdef ALU_ISSUE_FWD_EN
    if (ex_wr_en && !ex_is_load && ex_wr_addr == a) return ex_wr_data;
    if (wb_wr_en && wb_wr_addr == a) return wb_wr_data;
`endif
    return regs[a];
  endfunction

  // True when register a cannot be read yet.
  function automatic bit mblock(input logic [4:0] a);
    if (a == 0) return 0;
`ifdef ALU_ISSUE_FWD_EN
    return ex_wr_en && ex_is_load && ex_wr_addr == a;
`else
    return (ex_wr_en && ex_wr_addr == a) || (wb_wr_en && wb_wr_addr == a);
`endif
  endfunction

  // One clock: entered at posedge+2 with inputs driven, returns at the next posedge+2.
  task automatic tick();
    bit legal, uimm, urs, urt, wrk, ld, st, br, hz, adv, rdy, fire;
    logic [3:0] aop;
    logic [31:0] vrs, vrt, imm32;
    #1;
    mdec(in_opcode, legal, aop, uimm, urs, urt, wrk, ld, st, br);
    hz  = in_valid && ((urs && mblock(in_rs)) || (urt && mblock(in_rt)));
    adv = !m_valid || out_ready;
    rdy = adv && !hz;
    fire = in_valid && rdy;
    chk("in_ready", in_ready, rdy);
    chk("rf_addr", {rf_rs_addr, rf_rt_addr}, {in_rs, in_rt});
    vrs = mval(in_rs);
    vrt = mval(in_rt);
    imm32 = {{16{in_imm[15]}}, in_imm};
    @(posedge clk);
    #1;
    m_ill = fire && !legal;
    if (fire && legal) begin
      m_valid = 1; m_aop = aop; m_rd = in_rd;
      m_c1 = urs; m_d1 = vrs;
      m_c2 = uimm || urt; m_d2 = uimm ? imm32 : vrt;
      m_flags = {wrk && in_rd != 0, ld, st, br};
      m_sd = vrt;
    end else if (adv) begin
      m_valid = 0;
      if (hz && m_stall < 65535) m_stall++;
    end
    chk("out_valid", out_valid, m_valid);
    chk("illegal_op", illegal_op, m_ill);
    chk("stall_cnt", stall_cnt, m_stall);
    if (m_valid) begin
      chk("alu_op", alu_op, m_aop);
      chk("out_rd", out_rd, m_rd);
      chk("flags", {out_wr_en, out_is_load, out_is_store, out_is_branch}, m_flags);
      if (m_c1) chk("data1", data1, m_d1);
      if (m_c2) chk("data2", data2, m_d2);
      if (m_flags[1]) chk("store_data", out_store_data, m_sd);
    end
    #1;
  endtask

  task automatic set_instr(input bit v, input logic [5:0] op, input logic [4:0] rd, rs, rt,
                           input logic [15:0] imm);
    in_valid = v; in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
  endtask

  task automatic quiet_pipe();
    ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = 0; ex_wr_data = 0;
    wb_wr_en = 0; wb_wr_addr = 0; wb_wr_data = 0;
  endtask

  initial begin
    op_tab = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
               6'h10, 6'h11, 6'h12, 6'h13};
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
    reset_n = 0; out_ready = 1;
    set_instr(0, 0, 0, 0, 0, 0);
    quiet_pipe();
    m_valid = 0; m_ill = 0; m_stall = 0; m_c1 = 0; m_c2 = 0;
    m_aop = 0; m_flags = 0; m_d1 = 0; m_d2 = 0; m_sd = 0; m_rd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, alu_op, data1, data2, out_rd, out_wr_en, out_is_load,
                          out_is_store, out_is_branch, illegal_op}, 0);
    chk("reset_store_stall", {out_store_data, stall_cnt}, 0);
    reset_n = 1;
    #1;

    // ADD r3,r1,r2
    regs[1] = 5; regs[2] = 7;
    set_instr(1, 6'h00, 3, 1, 2, 0);
    tick();
    chk("add_result", {out_valid, alu_op, data1, data2, out_rd, out_wr_en},
        {1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1});

    // load-use on r4
    regs[4] = 9;
    ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 4; ex_wr_data = 32'hBAD;
    set_instr(1, 6'h01, 5, 4, 1, 0);
    #1;
    chk("lu_in_ready", in_ready, 0);
    tick();
    chk("lu_bubble", {out_valid, stall_cnt}, {1'b0, 16'd1});
    quiet_pipe();
    tick();
    chk("lu_issue", {out_valid, alu_op, data1, data2, stall_cnt},
        {1'b1, 4'd1, 32'd9, 32'd5, 16'd1});

`ifdef ALU_ISSUE_FWD_EN
    // EX beats WB on rs, imm = -1
    ex_wr_en = 1; ex_is_load = 0; ex_wr_addr = 1; ex_wr_data = 32'h10;
    wb_wr_en = 1; wb_wr_addr = 1; wb_wr_data = 32'h20;
    set_instr(1, 6'h10, 6, 1, 0, 16'hFFFF);
    tick();
    chk("fwd_addi", {out_valid, data1, data2}, {1'b1, 32'h10, 32'hFFFF_FFFF});
    quiet_pipe();
`else
    // WB write pending on rs: interlock until it drops, then regfile value
    regs[2] = 32'h77;
    wb_wr_en = 1; wb_wr_addr = 2; wb_wr_data = 32'h55;
    set_instr(1, 6'h10, 6, 2, 0, 16'h0003);
    for (int i = 0; i < 3; i++) tick();
    chk("nofwd_stall", {out_valid, stall_cnt}, {1'b0, 16'd4});
    quiet_pipe();
    tick();
    chk("nofwd_issue", {out_valid, data1, data2}, {1'b1, 32'h77, 32'd3});
    regs[2] = 7;
`endif

    // EX back-pressure for 3 cycles
    set_instr(1, 6'h00, 3, 1, 2, 0);
    tick();
    out_ready = 0;
    set_instr(1, 6'h04, 7, 1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_stable", {out_valid, alu_op, data1, data2, out_rd, in_ready},
          {1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b0});
    end
    out_ready = 1;
    tick();
    chk("hold_release", {out_valid, alu_op, out_rd}, {1'b1, 4'd4, 5'd7});

    // illegal opcode
    set_instr(1, 6'h3F, 1, 1, 1, 0);
    tick();
    chk("illegal_pulse", {illegal_op, out_valid}, {1'b1, 1'b0});
    set_instr(0, 0, 0, 0, 0, 0);
    tick();
    chk("illegal_clear", illegal_op, 0);

    // SW with r0 base: r0 reads as zero even if the regfile says otherwise
    regs[0] = 32'hDEAD;
    set_instr(1, 6'h12, 0, 0, 2, 16'h0004);
    tick();
    chk("sw_r0", {out_valid, data1, data2, out_wr_en, out_is_store, out_store_data},
        {1'b1, 32'd0, 32'd4, 1'b0, 1'b1, 32'd7});

    // random traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      regs[$urandom_range(0, 7)] = $urandom;
      r = $urandom_range(0, 15);
      set_instr($urandom_range(0, 3) != 0,
                (r < 13) ? op_tab[r] : 6'($urandom_range(20, 63)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                16'($urandom));
      ex_wr_en = $urandom_range(0, 1) == 1; ex_is_load = $urandom_range(0, 2) == 0;
      ex_wr_addr = 5'($urandom_range(0, 7)); ex_wr_data = $urandom;
      wb_wr_en = $urandom_range(0, 1) == 1;
      wb_wr_addr = 5'($urandom_range(0, 7)); wb_wr_data = $urandom;
      out_ready = $urandom_range(0, 9) < 7;
      tick();
    end

    // reset in the middle of an issued instruction
    quiet_pipe();
    out_ready = 1;
    set_instr(1, 6'h00, 3, 1, 2, 0);
    tick();
    out_ready = 0;
    reset_n = 0;
    #1;
    chk("midreset_clear", {out_valid, illegal_op, stall_cnt, alu_op, data1, data2}, 0);
    m_valid = 0; m_ill = 0; m_stall = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    out_ready = 1;
    set_instr(0, 0, 0, 0, 0, 0);
    #1;
    tick();
    chk("post_reset_idle", {out_valid, stall_cnt}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
